// File: rtl/chip8_audio_pkg.sv
// Shared types and defaults for the CHIP-8 buzzer tone generator.
package chip8_audio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int          SAMPLE_W          = 16;
    localparam logic [15:0] AMP_MAX_DEFAULT   = 16'h2000;
    localparam logic [15:0] RAMP_STEP_DEFAULT = 16'h0040;

endpackage

// File: rtl/tone_envelope.sv
// Linear attack/release envelope; advances one step per codec frame tick.
import chip8_audio_pkg::*;

module tone_envelope #(
    parameter logic [15:0] AMP_MAX   = AMP_MAX_DEFAULT,
    parameter logic [15:0] RAMP_STEP = RAMP_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        tone_en,
    output logic [15:0] amp,
    output env_state_t  state,
    output logic [15:0] amp_next,
    output env_state_t  state_next,
    output logic        busy
);

    logic [15:0] amp_reg;
    env_state_t  state_reg;

    logic [16:0] sum_wide;
    logic [16:0] diff_wide;
    logic [15:0] inc_amp;
    logic [15:0] dec_amp;
    env_state_t  inc_state;
    env_state_t  dec_state;

    // 17-bit arithmetic: carry/borrow bit flags saturation instead of wrapping.
    always_comb begin
        sum_wide  = {1'b0, amp_reg} + {1'b0, RAMP_STEP};
        diff_wide = {1'b0, amp_reg} - {1'b0, RAMP_STEP};
        if (sum_wide >= {1'b0, AMP_MAX}) begin
            inc_amp   = AMP_MAX;
            inc_state = SUSTAIN;
        end else begin
            inc_amp   = sum_wide[15:0];
            inc_state = ATTACK;
        end
        dec_amp   = diff_wide[16] ? 16'h0000 : diff_wide[15:0];
        dec_state = (dec_amp == 16'h0000) ? IDLE : RELEASE;
    end

    always_comb begin
        state_next = state_reg;
        amp_next   = amp_reg;
        if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (tone_en) begin
                        state_next = inc_state;
                        amp_next   = inc_amp;
                    end else begin
                        amp_next = 16'h0000;
                    end
                end
                ATTACK, RELEASE: begin
                    state_next = tone_en ? inc_state : dec_state;
                    amp_next   = tone_en ? inc_amp : dec_amp;
                end
                SUSTAIN: begin
                    state_next = tone_en ? SUSTAIN : dec_state;
                    amp_next   = tone_en ? AMP_MAX : dec_amp;
                end
                default: begin
                    state_next = IDLE;
                    amp_next   = 16'h0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            amp_reg   <= 16'h0000;
        end else begin
            state_reg <= state_next;
            amp_reg   <= amp_next;
        end
    end

    assign amp   = amp_reg;
    assign state = state_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: rtl/chip8_tone_gen.sv
// CHIP-8 buzzer: enveloped square wave, one sample per codec left-channel request.
import chip8_audio_pkg::*;

module chip8_tone_gen #(
    parameter int          PHASE_W   = 16,
    parameter logic [15:0] AMP_MAX   = AMP_MAX_DEFAULT,
    parameter logic [15:0] RAMP_STEP = RAMP_STEP_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          sample_req,
    input  logic                tone_en,
    input  logic [PHASE_W-1:0]  phase_inc,
    output logic [SAMPLE_W-1:0] audio_output,
    output logic [1:0]          channel_sel,
    output logic                busy
);

    logic               tick;
    logic [15:0]        amp;
    logic [15:0]        amp_next;
    env_state_t         state;
    env_state_t         state_next;
    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] phase_next;
    logic [15:0]        sample_next;
    logic [SAMPLE_W-1:0] audio_output_reg;

    // Right-channel requests reuse the left sample, so only bit 1 advances state.
    assign tick = sample_req[1];

    tone_envelope #(
        .AMP_MAX   (AMP_MAX),
        .RAMP_STEP (RAMP_STEP)
    ) u_env (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .tone_en    (tone_en),
        .amp        (amp),
        .state      (state),
        .amp_next   (amp_next),
        .state_next (state_next),
        .busy       (busy)
    );

    // Output is built from post-tick envelope and phase so it lands on the tick edge.
    always_comb begin
        phase_next  = (state_next == IDLE) ? '0 : phase_reg + phase_inc;
        sample_next = phase_next[PHASE_W-1] ? (16'h0000 - amp_next) : amp_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg        <= '0;
            audio_output_reg <= '0;
        end else if (tick) begin
            phase_reg        <= phase_next;
            audio_output_reg <= sample_next;
        end
    end

    assign audio_output = audio_output_reg;
    assign channel_sel  = 2'b11;

endmodule
